// File: rtl/gf2_karatsuba_mul_seq.sv
// +----------------------------------------------------------------------------+
// | gf2_karatsuba_mul_seq: multi-cycle carry-less multiplier, one Karatsuba      |
// | level on a shared HxH core, optional reduction mod (x^W + POLY).             |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf2_karatsuba_mul_seq #(
  parameter int           W    = 41,
  parameter logic [W-1:0] POLY = W'(9)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] c,
  output logic           busy
);

  localparam int L  = W / 2;
  localparam int H  = W - L;
  localparam int PW = 2 * H - 1;
  localparam int CW = 2 * W - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MUL_LL  = 3'd1;
  localparam logic [2:0] S_MUL_HH  = 3'd2;
  localparam logic [2:0] S_MUL_MID = 3'd3;
  localparam logic [2:0] S_COMBINE = 3'd4;
  localparam logic [2:0] S_REDUCE  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] pl_q, pl_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [PW-1:0] pm_q, pm_d;
  logic [CW-1:0] c_q, c_d;

  logic [H-1:0]  al_ext, bl_ext, ah, bh, am, bm;
  logic [H-1:0]  core_x, core_y;
  logic [PW-1:0] core_p;
  logic [PW-1:0] t_mid;
  logic [CW-1:0] p_comb;
  logic [CW-1:0] p_red;

  function automatic logic [PW-1:0] clmul(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < H; i++) begin
      if (y[i]) acc = acc ^ (PW'(x) << i);
    end
    return acc;
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid) state_d = S_MUL_LL;
      S_MUL_LL:  state_d = S_MUL_HH;
      S_MUL_HH:  state_d = S_MUL_MID;
      S_MUL_MID: state_d = S_COMBINE;
      S_COMBINE: state_d = mode_q ? S_REDUCE : S_DONE;
      S_REDUCE:  state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign c = c_q;

  // ---------------- Karatsuba split and shared core ----------------
  assign al_ext = H'(a_q[L-1:0]);
  assign bl_ext = H'(b_q[L-1:0]);
  assign ah     = a_q[W-1:L];
  assign bh     = b_q[W-1:L];
  assign am     = ah ^ al_ext;
  assign bm     = bh ^ bl_ext;

  always_comb begin
    core_x = am;
    core_y = bm;
    case (state_q)
      S_MUL_LL: begin
        core_x = al_ext;
        core_y = bl_ext;
      end
      S_MUL_HH: begin
        core_x = ah;
        core_y = bh;
      end
      default: ;
    endcase
  end

  assign core_p = clmul(core_x, core_y);

  // Middle term recovers Al*Bh ^ Ah*Bl; PH lands at 2L so odd W needs no special case.
  assign t_mid  = pm_q ^ ph_q ^ pl_q;
  assign p_comb = CW'(pl_q) ^ (CW'(t_mid) << L) ^ (CW'(ph_q) << (2 * L));

  // Fold from the top so bits created by a fold are themselves folded later.
  always_comb begin
    logic [CW-1:0] r;
    r = c_q;
    for (int i = CW - 1; i >= W; i--) begin
      if (r[i]) r = r ^ (CW'(POLY) << (i - W)) ^ (CW'(1) << i);
    end
    p_red = CW'(r[W-1:0]);
  end

  // ---------------- Datapath next-state ----------------
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    pl_d   = pl_q;
    ph_d   = ph_q;
    pm_d   = pm_q;
    c_d    = c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = a;
          b_d    = b;
          mode_d = mode;
        end
      end
      S_MUL_LL:  pl_d = core_p;
      S_MUL_HH:  ph_d = core_p;
      S_MUL_MID: pm_d = core_p;
      S_COMBINE: c_d  = p_comb;
      S_REDUCE:  c_d  = p_red;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      pl_q   <= '0;
      ph_q   <= '0;
      pm_q   <= '0;
      c_q    <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      pl_q   <= pl_d;
      ph_q   <= ph_d;
      pm_q   <= pm_d;
      c_q    <= c_d;
    end
  end

endmodule

`default_nettype wire
